// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back path.
// Used by the arbiter top, its bus interface and the pending-write scoreboard.
package regfile_pkg;

  localparam int RF_DW    = 16;
  localparam int RF_AW    = 4;
  localparam int RF_DEPTH = 16;
  localparam logic [3:0] RF_ZERO_REG = 4'd0;

  typedef logic [3:0]  rf_addr_t;
  typedef logic [15:0] rf_data_t;

  // Which requester wins the next contended cycle under round-robin.
  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the requesters/decode stage (master) and the arbiter (slave).
interface regfile_wb_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 4
);

  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              req0_valid;
  logic [AW-1:0]     req0_addr;
  logic [DW-1:0]     req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [AW-1:0]     req1_addr;
  logic [DW-1:0]     req1_data;
  logic              req1_ready;
  logic              wr_load;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [2**AW-1:0]  pending;

  modport master (
    output rsv_en, rsv_addr,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_load, wr_addr, wr_data, pending
  );

  modport slave (
    input  rsv_en, rsv_addr,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_load, wr_addr, wr_data, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reservation, cleared on commit.
module rf_scoreboard #(
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en_i,
  input  logic [AW-1:0]   set_addr_i,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_addr_i,
  output logic [2**AW-1:0] pending_o
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] pending_q, pending_d;

  // Set is applied after clear so a fresh reservation survives a same-cycle commit.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
    if (set_en_i) pending_d[set_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the register-file write port with a registered write stage.
// Optional macro REGFILE_WB_STATS_EN adds a saturating contention counter output.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DW        = RF_DW,
  parameter int AW        = RF_AW,
  parameter int LOAD_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
`ifdef REGFILE_WB_STATS_EN
  ,
  output logic [15:0]          conflict_cnt
`endif
);

  rr_ptr_e       rr_q, rr_d;
  logic          grant0, grant1, both_valid, any_grant;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_data;
  logic          wr_load_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  // Round-robin pointer moves only when both requesters compete.
  always_comb begin
    both_valid = bus.req0_valid & bus.req1_valid;
    grant0     = 1'b0;
    grant1     = 1'b0;
    rr_d       = rr_q;
    if (LOAD_PRIO != 0) begin
      grant1 = bus.req1_valid;
      grant0 = bus.req0_valid & ~bus.req1_valid;
    end else if (both_valid) begin
      grant0 = (rr_q == RR_REQ0);
      grant1 = (rr_q == RR_REQ1);
      rr_d   = (rr_q == RR_REQ0) ? RR_REQ1 : RR_REQ0;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  assign any_grant  = grant0 | grant1;
  assign grant_addr = grant1 ? bus.req1_addr : bus.req0_addr;
  assign grant_data = grant1 ? bus.req1_data : bus.req0_data;

  // Writes to register 0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= RR_REQ0;
      wr_load_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wr_load_q <= any_grant && (grant_addr != AW'(RF_ZERO_REG));
      if (any_grant) begin
        wr_addr_q <= grant_addr;
        wr_data_q <= grant_data;
      end
    end
  end

  rf_scoreboard #(.AW(AW)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (bus.rsv_en),
    .set_addr_i(bus.rsv_addr),
    .clr_en_i  (any_grant),
    .clr_addr_i(grant_addr),
    .pending_o (bus.pending)
  );

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.wr_load    = wr_load_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

`ifdef REGFILE_WB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 conflict_q <= '0;
    else if (both_valid && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a cycle-level reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checkCount = 0;
  int failCount = 0;

  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter_if busLp ();

`ifdef REGFILE_WB_STATS_EN
  logic [15:0] conflictCnt, conflictCntLp;
`endif

  regfile_wb_arbiter #(.LOAD_PRIO(0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef REGFILE_WB_STATS_EN
    , .conflict_cnt(conflictCnt)
`endif
  );

  regfile_wb_arbiter #(.LOAD_PRIO(1)) dutLp (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busLp)
`ifdef REGFILE_WB_STATS_EN
    , .conflict_cnt(conflictCntLp)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: what the register file should see next, and which registers await a write.
  logic        expWrLoad;
  logic [3:0]  expWrAddr;
  logic [15:0] expWrData;
  logic [15:0] expPending;
  int          favoured;
  int          lastGrant;
  int          expConflicts;

  logic        hv0, hv1;
  logic [3:0]  ha0, ha1;
  logic [15:0] hd0, hd1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    expWrLoad    = 1'b0;
    expWrAddr    = '0;
    expWrData    = '0;
    expPending   = '0;
    favoured     = 0;
    lastGrant    = -1;
    expConflicts = 0;
    hv0 = 1'b0;
    hv1 = 1'b0;
  endtask

  task automatic driveIdle();
    bus.rsv_en = 1'b0;      bus.rsv_addr = '0;
    bus.req0_valid = 1'b0;  bus.req0_addr = '0;  bus.req0_data = '0;
    bus.req1_valid = 1'b0;  bus.req1_addr = '0;  bus.req1_data = '0;
  endtask

  // Called at a falling edge: checks the previous edge's results, drives a new cycle, returns at the next falling edge.
  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                               input logic v1, input logic [3:0] a1, input logic [15:0] d1,
                               input logic rsv, input logic [3:0] ra);
    logic [3:0]  gAddr;
    logic [15:0] gData;
    checkOutput("wr_load", 32'(bus.wr_load), 32'(expWrLoad));
    if (expWrLoad) begin
      checkOutput("wr_addr", 32'(bus.wr_addr), 32'(expWrAddr));
      checkOutput("wr_data", 32'(bus.wr_data), 32'(expWrData));
    end
    checkOutput("pending", 32'(bus.pending), 32'(expPending));

    bus.req0_valid = v0;  bus.req0_addr = a0;  bus.req0_data = d0;
    bus.req1_valid = v1;  bus.req1_addr = a1;  bus.req1_data = d1;
    bus.rsv_en = rsv;     bus.rsv_addr = ra;
    #1;

    if (v0 && v1)  lastGrant = favoured;
    else if (v0)   lastGrant = 0;
    else if (v1)   lastGrant = 1;
    else           lastGrant = -1;
    checkOutput("req0_ready", 32'(bus.req0_ready), 32'(lastGrant == 0));
    checkOutput("req1_ready", 32'(bus.req1_ready), 32'(lastGrant == 1));

    if (v0 && v1) begin
      favoured = 1 - favoured;
      expConflicts++;
    end
    if (lastGrant >= 0) begin
      gAddr = (lastGrant == 1) ? a1 : a0;
      gData = (lastGrant == 1) ? d1 : d0;
      expWrLoad = (gAddr != 4'd0);
      if (expWrLoad) begin
        expWrAddr = gAddr;
        expWrData = gData;
      end
      expPending[gAddr] = 1'b0;
    end else begin
      expWrLoad = 1'b0;
    end
    if (rsv) expPending[ra] = 1'b1;
    expPending[0] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    resetModel();
    driveIdle();
    busLp.rsv_en = 1'b0;      busLp.rsv_addr = '0;
    busLp.req0_valid = 1'b0;  busLp.req0_addr = '0;  busLp.req0_data = '0;
    busLp.req1_valid = 1'b0;  busLp.req1_addr = '0;  busLp.req1_data = '0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_wr_load", 32'(bus.wr_load), 32'd0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("rst_pending", 32'(bus.pending), 32'd0);
    rst_n = 1'b1;

    // Single request, then reservation/commit interplay on register 5.
    applyStimulus(1'b1, 4'd3, 16'h0005, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5);
    applyStimulus(1'b1, 4'd5, 16'h0055, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5);
    applyStimulus(1'b1, 4'd5, 16'h0056, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);

    // Register 0: accepted, never written, never pending.
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);

    // Five contended cycles leave the pointer favouring req 1 before the reset.
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd0);

    applyStimulus(1'b1, 4'd7, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9);
    rst_n = 1'b0;
    driveIdle();
    #1;
    checkOutput("midrst_wr_load", 32'(bus.wr_load), 32'd0);
    checkOutput("midrst_pending", 32'(bus.pending), 32'd0);
    checkOutput("midrst_wr_addr", 32'(bus.wr_addr), 32'd0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd0);

    // Random traffic; an unaccepted request is held unchanged.
    for (int i = 0; i < 300; i++) begin
      if (!hv0) begin
        hv0 = 1'($urandom_range(0, 1));
        ha0 = 4'($urandom_range(0, 15));
        hd0 = 16'($urandom);
      end
      if (!hv1) begin
        hv1 = 1'($urandom_range(0, 1));
        ha1 = 4'($urandom_range(0, 15));
        hd1 = 16'($urandom);
      end
      applyStimulus(hv0, ha0, hd0, hv1, ha1, hd1,
                    1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
      if (lastGrant == 0) hv0 = 1'b0;
      if (lastGrant == 1) hv1 = 1'b0;
    end
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
`ifdef REGFILE_WB_STATS_EN
    checkOutput("conflict_cnt", 32'(conflictCnt), 32'(expConflicts));
`endif

    // Load-priority instance: req 1 wins every contended cycle.
    for (int k = 0; k < 3; k++) begin
      busLp.req0_valid = 1'b1;  busLp.req0_addr = 4'd1;  busLp.req0_data = 16'hAAAA;
      busLp.req1_valid = 1'b1;  busLp.req1_addr = 4'd6;  busLp.req1_data = 16'h1000 + 16'(k);
      #1;
      checkOutput("lp_req0_ready", 32'(busLp.req0_ready), 32'd0);
      checkOutput("lp_req1_ready", 32'(busLp.req1_ready), 32'd1);
      @(negedge clk);
      checkOutput("lp_wr_load", 32'(busLp.wr_load), 32'd1);
      checkOutput("lp_wr_addr", 32'(busLp.wr_addr), 32'd6);
      checkOutput("lp_wr_data", 32'(busLp.wr_data), 32'h1000 + 32'(k));
    end
    busLp.req0_valid = 1'b0;
    busLp.req1_valid = 1'b0;
    @(negedge clk);
`ifdef REGFILE_WB_STATS_EN
    checkOutput("lp_conflict_cnt", 32'(conflictCntLp), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 16x16 register file (write enable, 4-bit write address, 16-bit write data) between two write-back requesters: ALU write-back (req 0) and memory-load write-back (req 1).
- Registers the granted write so the register file samples it on the next rising clk.
- Keeps a 16-bit pending-write scoreboard that the hazard/stall logic reads, so dependent instructions wait until their source register has been committed.

Parameters:
- DW, 16, data width of the register file.
- AW, 4, register address width; the scoreboard holds 2**AW bits.
- LOAD_PRIO, 0, 0 = round-robin between requesters; 1 = req 1 (load) always wins.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rsv_en  in  1  decode stage reserves a destination register for a later write.
- rsv_addr  in  AW  register being reserved.
- req0_valid  in  1  ALU write-back request.
- req0_addr  in  AW  ALU destination register.
- req0_data  in  DW  ALU result.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load write-back request.
- req1_addr  in  AW  load destination register.
- req1_data  in  DW  load data.
- req1_ready  out  1  load request accepted this cycle.
- wr_load  out  1  write enable to the register file.
- wr_addr  out  AW  write address to the register file.
- wr_data  out  DW  write data to the register file.
- pending  out  2**AW  scoreboard; bit n set = register n has an outstanding write.

Behaviour:
- Reset (async, rst_n=0):
  - wr_load=0, wr_addr=0, wr_data=0, pending=0.
  - RR pointer = 0, meaning req 0 has priority next.
  - Any in-flight grant is dropped.
- Handshake:
  - A request transfers on a clk edge where valid=1 and ready=1.
  - ready is combinational from valid and the arbitration state.
  - At most one ready is asserted per cycle.
  - A requester must hold valid, addr and data stable until accepted.
- Arbitration with LOAD_PRIO=0:
  - Only one requester valid: it is granted.
  - Both valid: the RR pointer holder is granted, and the pointer then flips to the other requester.
  - The pointer changes only on a contended grant.
- Arbitration with LOAD_PRIO=1: req 1 wins whenever it is valid.
- Output timing:
  - A granted request appears on wr_load/wr_addr/wr_data at the next edge.
  - Latency from accept to register-file write is exactly 1 cycle.
  - Throughput is one write per cycle.
- Register 0:
  - A request with addr=0 is accepted and granted normally.
  - wr_load is forced to 0 for it, so register 0 stays zero.
  - rsv_addr=0 never sets pending[0]; pending[0] is always 0.
- Scoreboard, evaluated at each edge:
  - Set bit rsv_addr when rsv_en=1.
  - Clear bit addr of the accepted request.
  - Same-cycle set and clear of the same address: set wins, because a newer write is now outstanding.
- Two requests to the same address in consecutive cycles: both are written in grant order; the last one wins in the register file.
- Clearing a scoreboard bit that is already 0 is legal and a no-op.

Optional Feature:
- Macro: REGFILE_WB_STATS_EN.
- With the macro defined:
  - Adds output conflict_cnt [15:0].
  - Counts cycles where both requests are valid (one requester stalled).
  - Saturates at 16'hFFFF and resets to 0.
- Without the macro: the port and the counter logic are absent.

Decomposition:
- Shared package regfile_pkg holds:
  - constants RF_DW=16, RF_AW=4, RF_DEPTH=16, RF_ZERO_REG=4'd0;
  - typedef rf_addr_t (logic [3:0]);
  - typedef rf_data_t (logic [15:0]).
- One natural sub-module: rf_scoreboard, which holds the pending vector with its set/clear/priority logic.
- The arbiter and output register stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-stream with a grant in flight -> immediately wr_load=0 and pending=16'h0000; after release, the first write starts cleanly.
- Single request: req0 addr=3, data=16'h0005 -> req0_ready=1 the same cycle; next cycle wr_load=1, wr_addr=3, wr_data=16'h0005.
- Contention, RR: both valid for 4 cycles (req0 addr=1 data=A, req1 addr=2 data=B, each holding until accepted) -> grants alternate 0,1,0,1; no ready is ever double-asserted.
- Register 0: req1 addr=0 data=16'hFFFF -> req1_ready=1; wr_load stays 0; pending[0] stays 0.
- Scoreboard: rsv_en addr=5 -> pending=16'h0020; a later req0 addr=5 accepted in the same cycle as rsv_en addr=5 -> pending[5] remains 1; the next accepted write to 5 clears it.
- LOAD_PRIO=1 with both valid for 3 cycles -> req1 is granted every cycle; req0_ready=0 throughout. With REGFILE_WB_STATS_EN defined, conflict_cnt=3.
